// File: rtl/flsv_mem_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package flsv_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_BUSY = 3'd1,
        D_BUSY = 3'd2,
        I_RESP = 3'd3,
        D_RESP = 3'd4
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and
// data access. Data wins by default; a counter bounds how many data grants
// may pass a waiting fetch. A redirect can kill an outstanding fetch, in
// which case the bus access still runs to completion but its result is
// thrown away.
module mem_port_arbiter
    import flsv_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,

    output logic              bus_valid,
    output logic              bus_we,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              busy
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              kill_pend_q, kill_pend_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_we_q, bus_we_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;

    logic              fetch_live;
    logic              data_win;
    logic              fetch_win;

    // A fetch only competes when it has not been killed this cycle.
    assign fetch_live = if_req && !if_kill;
    assign data_win   = d_req && !(fetch_live && (starve_q == STARVE_LIM));
    assign fetch_win  = !data_win && fetch_live;

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            kill_pend_q <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_size_q  <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            kill_pend_q <= kill_pend_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for ack in BUSY, pulse done in RESP.
    always_comb begin
        state_d     = state_q;
        kill_pend_d = kill_pend_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (data_win) begin
                    bus_valid_d = 1'b1;
                    bus_we_d    = d_we;
                    bus_size_d  = d_size;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    state_d     = D_BUSY;
                end else if (fetch_win) begin
                    bus_valid_d = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_size_d  = SZ_WORD;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    state_d     = I_BUSY;
                end
            end
            I_BUSY: begin
                if (if_kill) begin
                    kill_pend_d = 1'b1;
                end
                if (bus_ack) begin
                    bus_valid_d = 1'b0;
                    if (!(kill_pend_q || if_kill)) begin
                        if_rdata_d = bus_rdata;
                        if_done_d  = 1'b1;
                    end
                    state_d = I_RESP;
                end
            end
            D_BUSY: begin
                if (bus_ack) begin
                    bus_valid_d = 1'b0;
                    if (!bus_we_q) begin
                        d_rdata_d = bus_rdata;
                    end
                    d_done_d = 1'b1;
                    state_d  = D_RESP;
                end
            end
            I_RESP: begin
                kill_pend_d = 1'b0;
                state_d     = IDLE;
            end
            D_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Anti-starvation counter: counts data grants that passed a live fetch.
    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = '0;
        end else if (state_q == IDLE && fetch_win) begin
            starve_d = '0;
        end else if (state_q == IDLE && data_win && fetch_live &&
                     starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table followed
// by hand-written starvation and fetch-kill sequences.
module tb_mem_port_arbiter;
    import flsv_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        bus_valid;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_kill(if_kill),
        .if_done(if_done),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_size(d_size),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_done(d_done),
        .d_rdata(d_rdata),
        .bus_valid(bus_valid),
        .bus_we(bus_we),
        .bus_size(bus_size),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream never terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic        rst;
        logic        ifReq;
        logic        ifKill;
        logic        dReq;
        logic        dWe;
        logic [1:0]  dSize;
        logic [31:0] ifAddr;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        ack;
        logic [31:0] rdata;
        logic        eValid;
        logic        eWe;
        logic [1:0]  eSize;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic        eIfDone;
        logic        eDDone;
        logic        eBusy;
        logic [31:0] eIfRdata;
        logic [31:0] eDRdata;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mkVec(
        input logic rst, input logic ifReq, input logic ifKill, input logic dReq,
        input logic dWe, input logic [1:0] dSize, input logic [31:0] ifAddr,
        input logic [31:0] dAddr, input logic [31:0] dWdata, input logic ack,
        input logic [31:0] rdata, input logic eValid, input logic eWe,
        input logic [1:0] eSize, input logic [31:0] eAddr, input logic [31:0] eWdata,
        input logic eIfDone, input logic eDDone, input logic eBusy,
        input logic [31:0] eIfRdata, input logic [31:0] eDRdata);
        vec_t v;
        v.rst = rst;       v.ifReq = ifReq;   v.ifKill = ifKill; v.dReq = dReq;
        v.dWe = dWe;       v.dSize = dSize;   v.ifAddr = ifAddr; v.dAddr = dAddr;
        v.dWdata = dWdata; v.ack = ack;       v.rdata = rdata;
        v.eValid = eValid; v.eWe = eWe;       v.eSize = eSize;   v.eAddr = eAddr;
        v.eWdata = eWdata; v.eIfDone = eIfDone; v.eDDone = eDDone; v.eBusy = eBusy;
        v.eIfRdata = eIfRdata; v.eDRdata = eDRdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        if_req    = v.ifReq;
        if_kill   = v.ifKill;
        if_addr   = v.ifAddr;
        d_req     = v.dReq;
        d_we      = v.dWe;
        d_size    = v.dSize;
        d_addr    = v.dAddr;
        d_wdata   = v.dWdata;
        bus_ack   = v.ack;
        bus_rdata = v.rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d.bus_valid", i), 32'(bus_valid), 32'(v.eValid));
        checkOutput($sformatf("v%0d.bus_we", i),    32'(bus_we),    32'(v.eWe));
        checkOutput($sformatf("v%0d.bus_size", i),  32'(bus_size),  32'(v.eSize));
        checkOutput($sformatf("v%0d.bus_addr", i),  bus_addr,       v.eAddr);
        checkOutput($sformatf("v%0d.bus_wdata", i), bus_wdata,      v.eWdata);
        checkOutput($sformatf("v%0d.if_done", i),   32'(if_done),   32'(v.eIfDone));
        checkOutput($sformatf("v%0d.d_done", i),    32'(d_done),    32'(v.eDDone));
        checkOutput($sformatf("v%0d.busy", i),      32'(busy),      32'(v.eBusy));
        checkOutput($sformatf("v%0d.if_rdata", i),  if_rdata,       v.eIfRdata);
        checkOutput($sformatf("v%0d.d_rdata", i),   d_rdata,        v.eDRdata);
    endtask

    // One clock with the given request/ack inputs; address/data inputs keep their values.
    task automatic driveCycle(input logic ifReq, input logic ifKill, input logic dReq,
                              input logic ack, input logic [31:0] rdata);
        rst       = 1'b0;
        if_req    = ifReq;
        if_kill   = ifKill;
        d_req     = dReq;
        bus_ack   = ack;
        bus_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] INS_A  = 32'h0050_0093;
    localparam logic [31:0] LD_B   = 32'hDEAD_BEEF;
    localparam logic [31:0] INS_C  = 32'h0000_0013;
    localparam logic [31:0] F_DATA = 32'h0000_AAAA;

    initial begin
        int expFetch [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int grants;
        int cycles;
        logic prevValid;

        rst = 1'b1; if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = SZ_BYTE; d_addr = '0; d_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;

        // Lone fetch, then simultaneous load+fetch, store, reset mid-access, stray ack.
        vecs[0]  = mkVec(1,0,0,0,0,SZ_BYTE,32'h0,   32'h0,   32'h0, 0,32'h0,     0,0,SZ_BYTE,32'h0,   32'h0, 0,0,0, 32'h0, 32'h0);
        vecs[1]  = mkVec(0,1,0,0,0,SZ_BYTE,32'h100, 32'h0,   32'h0, 0,32'h0,     1,0,SZ_WORD,32'h100, 32'h0, 0,0,1, 32'h0, 32'h0);
        vecs[2]  = mkVec(0,1,0,0,0,SZ_BYTE,32'h100, 32'h0,   32'h0, 1,INS_A,     0,0,SZ_WORD,32'h100, 32'h0, 1,0,1, INS_A, 32'h0);
        vecs[3]  = mkVec(0,0,0,0,0,SZ_BYTE,32'h100, 32'h0,   32'h0, 0,32'h0,     0,0,SZ_WORD,32'h100, 32'h0, 0,0,0, INS_A, 32'h0);
        vecs[4]  = mkVec(0,1,0,1,0,SZ_WORD,32'h104, 32'h2000,32'h0, 0,32'h0,     1,0,SZ_WORD,32'h2000,32'h0, 0,0,1, INS_A, 32'h0);
        vecs[5]  = mkVec(0,1,0,1,0,SZ_WORD,32'h104, 32'h2000,32'h0, 0,32'h0,     1,0,SZ_WORD,32'h2000,32'h0, 0,0,1, INS_A, 32'h0);
        vecs[6]  = mkVec(0,1,0,1,0,SZ_WORD,32'h104, 32'h2000,32'h0, 0,32'h0,     1,0,SZ_WORD,32'h2000,32'h0, 0,0,1, INS_A, 32'h0);
        vecs[7]  = mkVec(0,1,0,1,0,SZ_WORD,32'h104, 32'h2000,32'h0, 1,LD_B,      0,0,SZ_WORD,32'h2000,32'h0, 0,1,1, INS_A, LD_B);
        vecs[8]  = mkVec(0,1,0,0,0,SZ_BYTE,32'h104, 32'h0,   32'h0, 0,32'h0,     0,0,SZ_WORD,32'h2000,32'h0, 0,0,0, INS_A, LD_B);
        vecs[9]  = mkVec(0,1,0,0,0,SZ_BYTE,32'h104, 32'h0,   32'h0, 0,32'h0,     1,0,SZ_WORD,32'h104, 32'h0, 0,0,1, INS_A, LD_B);
        vecs[10] = mkVec(0,1,0,0,0,SZ_BYTE,32'h104, 32'h0,   32'h0, 1,INS_C,     0,0,SZ_WORD,32'h104, 32'h0, 1,0,1, INS_C, LD_B);
        vecs[11] = mkVec(0,0,0,0,0,SZ_BYTE,32'h0,   32'h0,   32'h0, 0,32'h0,     0,0,SZ_WORD,32'h104, 32'h0, 0,0,0, INS_C, LD_B);
        vecs[12] = mkVec(0,0,0,1,1,SZ_BYTE,32'h0,   32'h2003,32'hAB,0,32'h0,     1,1,SZ_BYTE,32'h2003,32'hAB,0,0,1, INS_C, LD_B);
        vecs[13] = mkVec(0,0,0,1,1,SZ_BYTE,32'h0,   32'h2003,32'hAB,0,32'h0,     1,1,SZ_BYTE,32'h2003,32'hAB,0,0,1, INS_C, LD_B);
        vecs[14] = mkVec(0,0,0,1,1,SZ_BYTE,32'h0,   32'h2003,32'hAB,1,32'h12345678,0,1,SZ_BYTE,32'h2003,32'hAB,0,1,1, INS_C, LD_B);
        vecs[15] = mkVec(0,0,0,0,0,SZ_BYTE,32'h0,   32'h0,   32'h0, 0,32'h0,     0,1,SZ_BYTE,32'h2003,32'hAB,0,0,0, INS_C, LD_B);
        vecs[16] = mkVec(0,0,0,1,0,SZ_WORD,32'h0,   32'h3000,32'h0, 0,32'h0,     1,0,SZ_WORD,32'h3000,32'h0, 0,0,1, INS_C, LD_B);
        vecs[17] = mkVec(1,0,0,1,0,SZ_WORD,32'h0,   32'h3000,32'h0, 0,32'h0,     0,0,SZ_BYTE,32'h0,   32'h0, 0,0,0, 32'h0, 32'h0);
        vecs[18] = mkVec(0,0,0,0,0,SZ_BYTE,32'h0,   32'h0,   32'h0, 0,32'h0,     0,0,SZ_BYTE,32'h0,   32'h0, 0,0,0, 32'h0, 32'h0);
        vecs[19] = mkVec(0,0,0,0,0,SZ_BYTE,32'h0,   32'h0,   32'h0, 1,32'hFFFF,  0,0,SZ_BYTE,32'h0,   32'h0, 0,0,0, 32'h0, 32'h0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Starvation: data held continuously with a fetch pending.
        if_addr = 32'h200; d_addr = 32'h4000; d_we = 1'b0; d_size = SZ_WORD; d_wdata = '0;
        grants = 0; cycles = 0; prevValid = bus_valid;
        while (grants < 10 && cycles < 300) begin
            driveCycle(1'b1, 1'b0, 1'b1, bus_valid,
                       (bus_addr == 32'h200) ? F_DATA : 32'h0000_5555);
            cycles++;
            if (bus_valid && !prevValid) begin
                checkOutput($sformatf("starve.grant%0d.isFetch", grants),
                            32'(bus_addr == 32'h200), 32'(expFetch[grants]));
                grants++;
            end
            prevValid = bus_valid;
        end
        checkOutput("starve.grantsSeen", 32'(grants), 32'd10);

        cycles = 0;
        while (busy && cycles < 20) begin
            driveCycle(1'b0, 1'b0, 1'b0, bus_valid, F_DATA);
            cycles++;
        end
        checkOutput("starve.drainIdle", 32'(busy), 32'd0);
        checkOutput("starve.lastFetchData", if_rdata, F_DATA);

        // Kill in IDLE suppresses the grant.
        if_addr = 32'h300;
        driveCycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("kill.idle.valid", 32'(bus_valid), 32'd0);
        driveCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("kill.grant.valid", 32'(bus_valid), 32'd1);
        checkOutput("kill.grant.addr", bus_addr, 32'h300);
        // Kill for one cycle in I_BUSY, ack three cycles later.
        driveCycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("kill.busy.if_done", 32'(if_done), 32'd0);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("kill.wait.valid", 32'(bus_valid), 32'd1);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0);
        checkOutput("kill.ack.valid", 32'(bus_valid), 32'd0);
        checkOutput("kill.ack.if_done", 32'(if_done), 32'd0);
        checkOutput("kill.ack.busy", 32'(busy), 32'd1);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("kill.resp.if_done", 32'(if_done), 32'd0);
        checkOutput("kill.resp.busy", 32'(busy), 32'd0);
        checkOutput("kill.resp.if_rdata", if_rdata, F_DATA);
        // Next fetch proceeds normally.
        if_addr = 32'h304;
        driveCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("refetch.valid", 32'(bus_valid), 32'd1);
        checkOutput("refetch.addr", bus_addr, 32'h304);
        driveCycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
        checkOutput("refetch.if_done", 32'(if_done), 32'd1);
        checkOutput("refetch.if_rdata", if_rdata, 32'h1111_1111);
        driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("refetch.idle", 32'(busy), 32'd0);
        checkOutput("refetch.done_once", 32'(if_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
